onehot_rr_encoder: RTL and testbench

ONEHOT_RR_ENCODER -- requirements
Module: onehot_rr_encoder

---
 rtl/onehot_rr_encoder_pkg.sv | 15 +
 rtl/onehot_rr_encoder_prio_pick.sv | 28 ++
 rtl/onehot_rr_encoder.sv | 160 ++++++++++++++++
 tb/tb_onehot_rr_encoder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_rr_encoder_pkg.sv
// Shared constants for the one-hot / priority / round-robin encoder.
//   MODE_STRICT : input must be one-hot; index is the OR of all set-bit indices
//   MODE_PRIO   : lowest set bit wins
//   MODE_RR     : first set bit at or above a rotating pointer wins
//   NUM_PORTS   : default request-vector width used when instantiating WIDTH
package onehot_rr_encoder_pkg;

  localparam int unsigned MODE_STRICT = 0;
  localparam int unsigned MODE_PRIO   = 1;
  localparam int unsigned MODE_RR     = 2;

  localparam int unsigned NUM_PORTS   = 8;
  localparam int unsigned ERR_CNT_W   = 8;

endpackage

// File: rtl/onehot_rr_encoder_prio_pick.sv
// Combinational lowest-set-bit picker.
//   i_vec    : request vector
//   o_onehot : one-hot of the lowest set bit (zero when i_vec == 0)
//   o_idx    : index of the lowest set bit (zero when i_vec == 0)
//   o_any    : i_vec has at least one bit set
module prio_pick #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BIN_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0] o_onehot,
  output logic [BIN_W-1:0] o_idx,
  output logic             o_any
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_onehot = i_vec & (~i_vec + WIDTH'(1));
  assign o_any    = |i_vec;

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = BIN_W'(i);
    end
  end

endmodule

// File: rtl/onehot_rr_encoder.sv
// One-hot / priority / round-robin encoder with a single registered output stage.
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_vec, in_valid    : request vector and its valid
//   in_ready            : stage can accept this cycle (!out_valid || out_ready)
//   out_bin, out_onehot : encoded index and one-hot of the selected bit
//   out_err             : input was illegal for the selected MODE
//   out_valid, out_ready: output handshake
//   err_cnt             : saturating count of accepted inputs flagged with an error
module onehot_rr_encoder
  import onehot_rr_encoder_pkg::*;
#(
  parameter  int unsigned WIDTH = NUM_PORTS,
  parameter  int unsigned MODE  = MODE_STRICT,
  localparam int unsigned BIN_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_vec,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIN_W-1:0]     out_bin,
  output logic [WIDTH-1:0]     out_onehot,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("onehot_rr_encoder: WIDTH must be in 2..64");
  end

  logic                 w_accept;
  logic                 w_xfer;
  logic [BIN_W-1:0]     w_sel_bin;
  logic [WIDTH-1:0]     w_sel_oh;
  logic                 w_sel_err;

  logic                 r_valid;
  logic [BIN_W-1:0]     r_bin;
  logic [WIDTH-1:0]     r_oh;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_valid && out_ready;

  if (MODE == MODE_STRICT) begin : g_strict
    // Illegal (multi-hot) inputs still produce a deterministic code: OR of indices.
    always_comb begin
      w_sel_bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (in_vec[i]) w_sel_bin = w_sel_bin | BIN_W'(i);
      end
    end
    assign w_sel_oh  = in_vec;
    assign w_sel_err = ($countones(in_vec) != 1);

  end else if (MODE == MODE_PRIO) begin : g_prio
    logic w_any;

    prio_pick #(
      .WIDTH (WIDTH),
      .BIN_W (BIN_W)
    ) u_pick (
      .i_vec    (in_vec),
      .o_onehot (w_sel_oh),
      .o_idx    (w_sel_bin),
      .o_any    (w_any)
    );

    assign w_sel_err = !w_any;

  end else if (MODE == MODE_RR) begin : g_rr
    logic [BIN_W-1:0] r_ptr;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_m_oh;
    logic [BIN_W-1:0] w_m_idx;
    logic             w_m_any;
    logic [WIDTH-1:0] w_u_oh;
    logic [BIN_W-1:0] w_u_idx;
    logic             w_u_any;
    logic [BIN_W-1:0] w_ptr_nxt;

    // Keep only requests at or above the pointer; fall back to the full vector
    // when none remain, which implements the wrap from WIDTH-1 to 0.
    always_comb begin
      w_mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
        w_mask[i] = (BIN_W'(i) >= r_ptr);
      end
    end

    prio_pick #(
      .WIDTH (WIDTH),
      .BIN_W (BIN_W)
    ) u_pick_masked (
      .i_vec    (in_vec & w_mask),
      .o_onehot (w_m_oh),
      .o_idx    (w_m_idx),
      .o_any    (w_m_any)
    );

    prio_pick #(
      .WIDTH (WIDTH),
      .BIN_W (BIN_W)
    ) u_pick_full (
      .i_vec    (in_vec),
      .o_onehot (w_u_oh),
      .o_idx    (w_u_idx),
      .o_any    (w_u_any)
    );

    assign w_sel_oh  = w_m_any ? w_m_oh  : w_u_oh;
    assign w_sel_bin = w_m_any ? w_m_idx : w_u_idx;
    assign w_sel_err = !w_u_any;
    assign w_ptr_nxt = (w_sel_bin == BIN_W'(WIDTH - 1)) ? '0 : w_sel_bin + BIN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ptr <= '0;
      end else if (w_accept && w_u_any) begin
        r_ptr <= w_ptr_nxt;
      end
    end

  end else begin : g_bad_mode
    $error("onehot_rr_encoder: MODE must be 0, 1 or 2");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_bin     <= '0;
      r_oh      <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_bin   <= w_sel_bin;
        r_oh    <= w_sel_oh;
        r_err   <= w_sel_err;
        if (w_sel_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign in_ready   = !r_valid || out_ready;
  assign out_valid  = r_valid;
  assign out_bin    = r_bin;
  assign out_onehot = r_oh;
  assign out_err    = r_err;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_onehot_rr_encoder.sv
// Bench for onehot_rr_encoder: three instances (W8/strict, W8/priority, W5/round-robin)
// share one stimulus port; dut_sel picks which one is active. Expected outputs are
// pushed to a scoreboard on accept and popped on transfer.
module tb_onehot_rr_encoder;

  typedef struct packed {
    logic [2:0] bin;
    logic [7:0] oh;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_vec;
  logic       in_valid;
  logic       out_ready;
  int         dut_sel;
  bit         rand_rdy;

  logic       rdy0, rdy1, rdy2, vld0, vld1, vld2, err0, err1, err2;
  logic [2:0] bin0, bin1, bin2;
  logic [7:0] oh0, oh1;
  logic [4:0] oh2;
  logic [7:0] cnt0, cnt1, cnt2;

  logic       obs_ready, obs_valid, obs_err;
  logic [2:0] obs_bin;
  logic [7:0] obs_oh, obs_cnt;

  exp_t       sb_q[$];
  int         m_ptr;
  logic [7:0] m_cnt;
  int         n_checks = 0;
  int         n_errs   = 0;

  always #5 clk = ~clk;

  onehot_rr_encoder #(.WIDTH(8), .MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid && dut_sel == 0),
    .in_ready(rdy0), .out_bin(bin0), .out_onehot(oh0), .out_err(err0),
    .out_valid(vld0), .out_ready(out_ready), .err_cnt(cnt0)
  );

  onehot_rr_encoder #(.WIDTH(8), .MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid && dut_sel == 1),
    .in_ready(rdy1), .out_bin(bin1), .out_onehot(oh1), .out_err(err1),
    .out_valid(vld1), .out_ready(out_ready), .err_cnt(cnt1)
  );

  onehot_rr_encoder #(.WIDTH(5), .MODE(2)) u_m2 (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec[4:0]), .in_valid(in_valid && dut_sel == 2),
    .in_ready(rdy2), .out_bin(bin2), .out_onehot(oh2), .out_err(err2),
    .out_valid(vld2), .out_ready(out_ready), .err_cnt(cnt2)
  );

  always_comb begin
    obs_ready = rdy0; obs_valid = vld0; obs_err = err0;
    obs_bin   = bin0; obs_oh    = oh0;  obs_cnt = cnt0;
    if (dut_sel == 1) begin
      obs_ready = rdy1; obs_valid = vld1; obs_err = err1;
      obs_bin   = bin1; obs_oh    = oh1;  obs_cnt = cnt1;
    end else if (dut_sel == 2) begin
      obs_ready = rdy2; obs_valid = vld2; obs_err = err2;
      obs_bin   = bin2; obs_oh    = {3'b000, oh2}; obs_cnt = cnt2;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour of the selected instance.
  function automatic void model(input int sel, input logic [7:0] v_in, input int ptr,
                                output exp_t e, output int nptr);
    int         w;
    logic [7:0] v;
    bit         found;
    w     = (sel == 2) ? 5 : 8;
    v     = (sel == 2) ? (v_in & 8'h1F) : v_in;
    e     = '0;
    nptr  = ptr;
    found = 0;
    if (sel == 0) begin
      e.oh = v;
      for (int i = 0; i < 8; i++) if (v[i]) e.bin = e.bin | 3'(i);
      e.err = ($countones(v) != 1);
    end else if (v == 8'h00) begin
      e.err = 1'b1;
    end else if (sel == 1) begin
      for (int i = 0; i < 8; i++) begin
        if (!found && v[i]) begin
          found = 1; e.bin = 3'(i);
        end
      end
      e.oh = 8'h01 << e.bin;
    end else begin
      for (int k = 0; k < w; k++) begin
        int idx;
        idx = (ptr + k) % w;
        if (!found && v[idx]) begin
          found = 1; e.bin = 3'(idx);
        end
      end
      e.oh = 8'h01 << e.bin;
      nptr = (int'(e.bin) == w - 1) ? 0 : int'(e.bin) + 1;
    end
  endfunction

  // Monitor on the falling edge: inputs and outputs are stable for the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_ptr = 0;
      m_cnt = 8'd0;
    end else begin
      exp_t e;
      int   np;
      check_eq("valid_vs_sb", obs_valid, sb_q.size() != 0);
      check_eq("in_ready", obs_ready, (sb_q.size() == 0) || out_ready);
      check_eq("err_cnt", obs_cnt, m_cnt);
      if (sb_q.size() != 0) begin
        e = sb_q[0];
        check_eq("out_bin", obs_bin, e.bin);
        check_eq("out_onehot", obs_oh, e.oh);
        check_eq("out_err", obs_err, e.err);
        if (out_ready) void'(sb_q.pop_front());
      end
      if (in_valid && obs_ready) begin
        model(dut_sel, in_vec, m_ptr, e, np);
        sb_q.push_back(e);
        m_ptr = np;
        if (e.err && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
    end
  end

  task automatic send(input logic [7:0] v, output int waited);
    in_vec   = v;
    in_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (obs_ready) break;
      waited++;
      if (waited > 50) begin
        check_eq("send_timeout", waited, 0);
        break;
      end
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send1(input logic [7:0] v);
    int w;
    send(v, w);
  endtask

  task automatic idle_drain();
    in_valid  = 1'b0;
    rand_rdy  = 0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("drained", obs_valid, 0);
  endtask

  task automatic do_reset(input int sel);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    dut_sel  = sel;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("post_rst_ready", obs_ready, 1);
  endtask

  function automatic logic [7:0] rand_vec();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'h01 << $urandom_range(0, 7);
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic random_phase(input int n);
    rand_rdy = 1;
    repeat (n) send1(rand_vec());
    idle_drain();
  endtask

  task automatic backpressure(input logic [7:0] va, input logic [7:0] vb,
                              input logic [7:0] vc, input logic [7:0] vd);
    int w;
    out_ready = 1'b0;
    send1(va);
    in_vec = vb;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_ready", obs_ready, 0);
      check_eq("bp_valid", obs_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(vb, w); check_eq("b2b_stall_b", w, 0);
    send(vc, w); check_eq("b2b_stall_c", w, 0);
    send(vd, w); check_eq("b2b_stall_d", w, 0);
    idle_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rr_exp [4];
    rst_n     = 1'b0;
    in_vec    = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dut_sel   = 0;
    rand_rdy  = 0;
    rr_exp    = '{3'd0, 3'd1, 3'd4, 3'd0};

    #1;
    check_eq("rst_ready", obs_ready, 1);
    check_eq("rst_valid", obs_valid, 0);
    check_eq("rst_bin", obs_bin, 0);
    check_eq("rst_onehot", obs_oh, 0);
    check_eq("rst_err", obs_err, 0);
    check_eq("rst_cnt", obs_cnt, 0);

    // Strict one-hot mode.
    do_reset(0);
    send1(8'h20);
    check_eq("m0_bin_20", obs_bin, 5);
    check_eq("m0_oh_20", obs_oh, 8'h20);
    check_eq("m0_err_20", obs_err, 0);
    send1(8'h06);
    check_eq("m0_bin_06", obs_bin, 3);
    check_eq("m0_err_06", obs_err, 1);
    check_eq("m0_cnt_06", obs_cnt, 1);
    send1(8'h00);
    check_eq("m0_bin_00", obs_bin, 0);
    check_eq("m0_err_00", obs_err, 1);
    send1(8'h80);
    send1(8'hFF);
    idle_drain();
    random_phase(60);
    backpressure(8'h01, 8'h41, 8'h00, 8'h08);

    // Fixed-priority mode.
    do_reset(1);
    send1(8'hA4);
    check_eq("m1_bin_a4", obs_bin, 2);
    check_eq("m1_oh_a4", obs_oh, 8'h04);
    check_eq("m1_err_a4", obs_err, 0);
    send1(8'h00);
    check_eq("m1_bin_00", obs_bin, 0);
    check_eq("m1_oh_00", obs_oh, 0);
    check_eq("m1_err_00", obs_err, 1);
    send1(8'h80);
    idle_drain();
    random_phase(60);
    backpressure(8'hC0, 8'h18, 8'h00, 8'hFF);
    repeat (300) send1(8'h00);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("m1_cnt_sat", obs_cnt, 8'hFF);
    out_ready = 1'b0;
    send1(8'h10);
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", obs_valid, 0);
    check_eq("async_rst_cnt", obs_cnt, 0);
    check_eq("async_rst_ready", obs_ready, 1);
    check_eq("async_rst_oh", obs_oh, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send1(8'h08);
    check_eq("m1_after_rst_bin", obs_bin, 3);
    check_eq("m1_after_rst_cnt", obs_cnt, 0);
    idle_drain();

    // Round-robin mode, WIDTH=5.
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      send1(8'b0001_0011);
      check_eq("m2_rr_seq", obs_bin, rr_exp[i]);
    end
    idle_drain();
    random_phase(80);
    backpressure(8'h1F, 8'h1F, 8'h00, 8'h11);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
